// File: rtl/fwd_unit_hist_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit_hist_if
// Brief    : EX-stage producer, operand lookup and stall bundle for fwd_unit_hist.
// Revision : 1.0
// ============================================================================
interface fwd_unit_hist_if #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2
);
    logic                        enable;
    logic                        ex_valid;
    logic                        ex_wb;
    logic                        ex_is_load;
    logic [REG_W-1:0]            ex_dst_num;
    logic [DATA_W-1:0]           ex_result;
    logic [DATA_W-1:0]           mem_load_value;
    logic [NUM_SRC*REG_W-1:0]    src_num;
    logic [NUM_SRC-1:0]          fwd_hit;
    logic [NUM_SRC*DATA_W-1:0]   fwd_value;
    logic                        stall;
    logic [15:0]                 stall_count;

    modport master (
        output enable, ex_valid, ex_wb, ex_is_load, ex_dst_num, ex_result,
               mem_load_value, src_num,
        input  fwd_hit, fwd_value, stall, stall_count
    );

    modport slave (
        input  enable, ex_valid, ex_wb, ex_is_load, ex_dst_num, ex_result,
               mem_load_value, src_num,
        output fwd_hit, fwd_value, stall, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fwd_unit_hist.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit_hist
// Brief    : DEPTH-entry write history behind EX; resolves NUM_SRC operands
//            youngest-first and stalls one cycle on load-use hazards.
//            Optional stall counter enabled by macro FWD_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module fwd_unit_hist #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
) (
    input  logic               clk,
    input  logic               rst,
    fwd_unit_hist_if.slave     bus
);

    // History storage, entry 0 is the youngest producer.
    logic [DEPTH-1:0]               r_valid_q;
    logic [DEPTH-1:0]               w_valid_d;
    logic [DEPTH-1:0]               r_ready_q;
    logic [DEPTH-1:0]               w_ready_d;
    logic [DEPTH-1:0][REG_W-1:0]    r_num_q;
    logic [DEPTH-1:0][REG_W-1:0]    w_num_d;
    logic [DEPTH-1:0][DATA_W-1:0]   r_value_q;
    logic [DEPTH-1:0][DATA_W-1:0]   w_value_d;

    logic [NUM_SRC-1:0]              w_found;
    logic [NUM_SRC-1:0]              w_found_rdy;
    logic [NUM_SRC-1:0][DATA_W-1:0]  w_found_val;
    logic [NUM_SRC-1:0]              w_hit;
    logic [NUM_SRC*DATA_W-1:0]       w_fwd_value;
    logic [NUM_SRC-1:0]              w_stall_req;
    logic                            w_stall;

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        w_found     = '0;
        w_found_rdy = '0;
        w_found_val = '0;
        w_hit       = '0;
        w_fwd_value = '0;
        w_stall_req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_valid_q[k] && (r_num_q[k] == bus.src_num[i*REG_W +: REG_W])) begin
                    w_found[i]     = 1'b1;
                    w_found_rdy[i] = r_ready_q[k];
                    w_found_val[i] = r_value_q[k];
                end
            end
            w_hit[i]       = bus.enable & w_found[i] & w_found_rdy[i];
            w_stall_req[i] = bus.enable & w_found[i] & ~w_found_rdy[i];
            if (w_hit[i]) begin
                w_fwd_value[i*DATA_W +: DATA_W] = w_found_val[i];
            end
        end
    end

    assign w_stall       = |w_stall_req;
    assign bus.fwd_hit   = w_hit;
    assign bus.fwd_value = w_fwd_value;
    assign bus.stall     = w_stall;

    always_comb begin
        w_valid_d = r_valid_q;
        w_ready_d = r_ready_q;
        w_num_d   = r_num_q;
        w_value_d = r_value_q;

        // A stalled EX instruction is replayed next cycle, so a bubble enters now.
        if (w_stall) begin
            w_valid_d[0] = 1'b0;
            w_ready_d[0] = 1'b1;
            w_num_d[0]   = '0;
            w_value_d[0] = '0;
        end else begin
            w_valid_d[0] = bus.ex_valid & bus.ex_wb;
            w_ready_d[0] = ~bus.ex_is_load;
            w_num_d[0]   = bus.ex_dst_num;
            w_value_d[0] = bus.ex_result;
        end

        for (int k = 1; k < DEPTH; k++) begin
            w_valid_d[k] = r_valid_q[k-1];
            w_num_d[k]   = r_num_q[k-1];
            w_ready_d[k] = 1'b1;
            if ((k == 1) && !r_ready_q[0]) begin
                w_value_d[k] = bus.mem_load_value;
            end else begin
                w_value_d[k] = r_value_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= '0;
            r_ready_q <= '1;
            r_num_q   <= '0;
            r_value_q <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_ready_q <= w_ready_d;
            r_num_q   <= w_num_d;
            r_value_q <= w_value_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [15:0] r_stall_count_q;
    logic [15:0] w_stall_count_d;

    always_comb begin
        w_stall_count_d = r_stall_count_q;
        if (w_stall && (r_stall_count_q != c_cnt_max)) begin
            w_stall_count_d = r_stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count_q <= '0;
        end else begin
            r_stall_count_q <= w_stall_count_d;
        end
    end

    assign bus.stall_count = r_stall_count_q;
`else
    assign bus.stall_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_unit_hist.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_unit_hist
// Brief    : Directed self-checking bench for fwd_unit_hist (DEPTH=3, 2 srcs).
// Revision : 1.0
// ============================================================================
module tb_fwd_unit_hist;
    localparam int DATA_W  = 16;
    localparam int REG_W   = 4;
    localparam int DEPTH   = 3;
    localparam int NUM_SRC = 2;
`ifdef FWD_PERF_CNT_EN
    localparam bit C_CNT_ON = 1'b1;
`else
    localparam bit C_CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fwd_unit_hist_if #(.DATA_W(DATA_W), .REG_W(REG_W), .NUM_SRC(NUM_SRC)) bus ();

    fwd_unit_hist #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH),
        .NUM_SRC(NUM_SRC)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex_idle();
        bus.ex_valid   = 1'b0;
        bus.ex_wb      = 1'b0;
        bus.ex_is_load = 1'b0;
        bus.ex_dst_num = '0;
        bus.ex_result  = '0;
    endtask

    task automatic ex_set(input logic [3:0] dst, input logic [15:0] res, input logic ld);
        bus.ex_valid   = 1'b1;
        bus.ex_wb      = 1'b1;
        bus.ex_is_load = ld;
        bus.ex_dst_num = dst;
        bus.ex_result  = res;
    endtask

    task automatic srcs(input logic [3:0] s0, input logic [3:0] s1);
        bus.src_num = {s1, s0};
    endtask

    // fwd_value packs operand 1 in [31:16], operand 0 in [15:0].
    task automatic check_out(input string tag, input logic [1:0] hit, input logic [31:0] val,
                             input logic stall);
        check({tag, "_hit"},   {30'd0, bus.fwd_hit}, {30'd0, hit});
        check({tag, "_val"},   bus.fwd_value, val);
        check({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, stall});
    endtask

    initial begin
        rst                = 1'b1;
        bus.enable         = 1'b1;
        bus.mem_load_value = '0;
        ex_idle();
        srcs(4'd0, 4'd0);
        repeat (2) @(negedge clk);

        rst = 1'b0;
        srcs(4'd3, 4'd7);
        #1;
        check_out("reset", 2'b00, 32'h0, 1'b0);
        check("reset_cnt", {16'd0, bus.stall_count}, 32'd0);

        // Non-load producer R3 is visible for DEPTH cycles.
        @(negedge clk);
        ex_set(4'd3, 16'hABCD, 1'b0);
        #1;
        check_out("r3_pre", 2'b00, 32'h0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ex_idle();
            #1;
            check_out($sformatf("r3_c%0d", c), 2'b01, 32'h0000_ABCD, 1'b0);
        end
        @(negedge clk);
        #1;
        check_out("r3_gone", 2'b00, 32'h0, 1'b0);

        // Consecutive writes to R5, youngest wins.
        ex_set(4'd5, 16'h1111, 1'b0);
        srcs(4'd3, 4'd5);
        @(negedge clk);
        ex_set(4'd5, 16'h2222, 1'b0);
        #1;
        check_out("r5_first", 2'b10, 32'h1111_0000, 1'b0);
        @(negedge clk);
        ex_idle();
        #1;
        check_out("r5_young", 2'b10, 32'h2222_0000, 1'b0);
        @(negedge clk);
        #1;
        check_out("r5_hold", 2'b10, 32'h2222_0000, 1'b0);

        // Load-use on R6; R4 offered during the stall must be bubbled.
        ex_set(4'd6, 16'hDEAD, 1'b1);
        srcs(4'd6, 4'd4);
        @(negedge clk);
        ex_set(4'd4, 16'h4444, 1'b0);
        bus.mem_load_value = 16'h2486;
        #1;
        check_out("ld_stall", 2'b00, 32'h0, 1'b1);
        @(negedge clk);
        ex_idle();
        bus.mem_load_value = 16'h0;
        #1;
        check_out("ld_fwd", 2'b01, 32'h0000_2486, 1'b0);
        check("ld_cnt", {16'd0, bus.stall_count}, C_CNT_ON ? 32'd1 : 32'd0);

        // Unready younger R2 stalls despite a ready older R2.
        ex_set(4'd2, 16'h5555, 1'b0);
        srcs(4'd2, 4'd2);
        @(negedge clk);
        #1;
        check_out("r2_ready", 2'b11, 32'h5555_5555, 1'b0);
        ex_set(4'd2, 16'hBEEF, 1'b1);
        @(negedge clk);
        ex_idle();
        bus.mem_load_value = 16'h7777;
        #1;
        check_out("r2_ld_stall", 2'b00, 32'h0, 1'b1);
        @(negedge clk);
        bus.mem_load_value = 16'h0;
        #1;
        check_out("r2_ld_fwd", 2'b11, 32'h7777_7777, 1'b0);
        check("r2_cnt", {16'd0, bus.stall_count}, C_CNT_ON ? 32'd2 : 32'd0);

        // Enable gating: history keeps shifting while outputs are forced off.
        ex_set(4'd3, 16'h3333, 1'b0);
        srcs(4'd3, 4'd0);
        @(negedge clk);
        ex_idle();
        bus.enable = 1'b0;
        #1;
        check_out("en_off", 2'b00, 32'h0, 1'b0);
        @(negedge clk);
        bus.enable = 1'b1;
        #1;
        check_out("en_on_h1", 2'b01, 32'h0000_3333, 1'b0);

        // Reset discards a pending load.
        ex_set(4'd6, 16'h0BAD, 1'b1);
        srcs(4'd6, 4'd6);
        @(negedge clk);
        ex_idle();
        bus.mem_load_value = 16'h1357;
        #1;
        check_out("rst_pend", 2'b00, 32'h0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_load_value = 16'h0;
        #1;
        check_out("rst_after", 2'b00, 32'h0, 1'b0);
        check("rst_cnt", {16'd0, bus.stall_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fwd_unit_hist.md
# fwd_unit_hist

Parametrised operand-forwarding unit for the five-stage pipeline, successor to the fixed two-destination ALU-to-ALU forwarder. Keeps a DEPTH-entry shift-register history of in-flight register writes behind EX and resolves NUM_SRC source operands of the instruction in EX against it, youngest producer first. Detects load-use hazards (matching producer whose data is not yet available), raises `stall`, and inserts a bubble into its own history.

## Interface
- `DATA_W`, 16: register/data width.
- `REG_W`, 4: register-number width (R0–R7, PC=8, SP=9).
- `DEPTH`, 3: history entries tracked (EX/MEM … WB); ≥2.
- `NUM_SRC`, 2: source operands resolved per cycle.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `enable`  in  1: forwarding enable.
- `ex_valid`  in  1: EX holds a real instruction.
- `ex_wb`  in  1: EX instruction writes a register.
- `ex_is_load`  in  1: EX instruction is a load; result arrives from memory one stage later.
- `ex_dst_num`  in  REG_W: EX destination register.
- `ex_result`  in  DATA_W: EX ALU result.
- `mem_load_value`  in  DATA_W: load data for the load currently in history entry 0.
- `src_num`  in  NUM_SRC*REG_W: source numbers; operand i at `[i*REG_W +: REG_W]`.
- `fwd_hit`  out  NUM_SRC: operand i forwarded.
- `fwd_value`  out  NUM_SRC*DATA_W: forwarded values, same packing.
- `stall`  out  1: load-use hazard; hold IF/ID/EX.
- `stall_count`  out  16: stall cycles (only with FWD_PERF_CNT_EN).

## Operation
- Entry H[k] = {valid, num, value, ready}; H[0] youngest.
- Lookup (combinational), per operand i: scan H[0..DEPTH-1]; first valid entry with num == src i decides.
  - ready → `fwd_hit[i]`=1, value forwarded.
  - not ready → `fwd_hit[i]`=0, operand requests stall.
  - no match → `fwd_hit[i]`=0, `fwd_value` slice = 0 (never Z).
- `stall` = OR of operand stall requests.
- `enable`=0: all `fwd_hit`=0, values 0, `stall`=0; history still updates.
- Update every rising edge:
  - H[k] <= H[k-1] for k≥1; older entries drop off H[DEPTH-1].
  - H[1] from a not-ready H[0]: value <= `mem_load_value`, ready <= 1.
  - H[0] <= {ex_valid&ex_wb, ex_dst_num, ex_result, !ex_is_load} when `stall`=0; invalid bubble when `stall`=1 (stalled EX instruction re-enters next cycle).
- Duplicate destinations: youngest wins; an unready younger match stalls even if an older ready match exists.
- Only H[0] can be unready; loads are ready from H[1] onward.

## Timing
- Lookup zero latency: outputs valid same cycle as `src_num`/history.
- Producer visible one cycle after it leaves EX, for DEPTH cycles (non-load); load stalls exactly one cycle then forwards from H[1].
- Reset values: all H[k].valid=0, `fwd_hit`=0, `fwd_value`=0, `stall`=0, `stall_count`=0. `rst` overrides update the same edge; reset during a pending load discards it.

## Configuration
- `FWD_PERF_CNT_EN` defined: `stall_count` increments each cycle `stall`=1 (while `enable`=1), saturates at 16'hFFFF, cleared by `rst`.
- Undefined: no counter logic; `stall_count` tied to 0.

## Test plan
- After `rst`, src0=R3, src1=R7 -> `fwd_hit`=00, values 0, `stall`=0.
- EX writes R3=16'hABCD (non-load), then src0=R3 -> hit, 16'hABCD for 3 cycles with idle EX; 4th cycle miss.
- Consecutive producers R5=16'h1111 then R5=16'h2222; src1=R5 -> 16'h2222; next cycle with EX idle still 16'h2222.
- Load R6 leaves EX; src0=R6 -> `stall`=1, hit 0; `mem_load_value`=16'h2486 at edge -> next cycle hit 16'h2486, `stall`=0, H[0] bubble; with macro `stall_count`=1.
- `enable`=0 with R3 match in H[0] -> hit 0, `stall`=0; `enable`=1 next cycle -> R3 found in H[1].
- Pending load R6 plus `rst` pulse -> next cycle src0=R6 miss, `stall`=0, `stall_count`=0.
